// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch controls in, instruction-memory port, IF/ID outputs.
interface fetch_stage_if #(
  parameter int INSTR_W = 8,
  parameter int PC_W    = 8,
  parameter int CNT_W   = 8
);
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic               if_id_valid;
  logic [1:0]         id_src_reg1;
  logic [1:0]         id_src_reg2;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid,
           id_src_reg1, id_src_reg2, stall_cycles
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid,
           id_src_reg1, id_src_reg2, stall_cycles
  );
endinterface

// File: rtl/fetch_stage.sv
// PC + IF/ID register, 1-cycle fetch-to-decode; stall freezes everything, taken branch
// redirects PC and inserts one bubble (flush beats stall); saturating stall-cycle counter.
module fetch_stage #(
  parameter int                 INSTR_W   = 8,
  parameter int                 PC_W      = 8,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 8
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  localparam if_id_t BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

  logic [PC_W-1:0]  pc_q, pc_d;
  if_id_t           if_id_q, if_id_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    pc_d        = pc_q;
    if_id_d     = if_id_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.branch_taken) begin
      // The ID instruction is younger than the branch, so it dies even if stalled.
      pc_d    = bus.branch_target;
      if_id_d = BUBBLE;
    end else if (bus.stall) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      if_id_d.valid = 1'b1;
      if_id_d.pc    = pc_q;
      if_id_d.instr = bus.imem_rdata;
      pc_d          = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      if_id_q     <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.if_id_instr  = if_id_q.instr;
  assign bus.if_id_pc     = if_id_q.pc;
  assign bus.if_id_valid  = if_id_q.valid;
  assign bus.id_src_reg1  = if_id_q.instr[3:2];
  assign bus.id_src_reg2  = if_id_q.instr[1:0];
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 4-register pipelined core. It holds the program counter and drives the instruction-memory address. It latches the fetched instruction into the IF/ID register and presents the decoded source-register fields to the hazard detection unit. It obeys that unit's `stall` by freezing, and it squashes its contents on a taken branch resolved in Execute. A saturating stall-cycle counter is included for performance debug.

## Interface
- `INSTR_W`, 8: instruction width.
- `PC_W`, 8: program counter width; also the instruction-memory address width.
- `RESET_PC`, 0: PC value after reset.
- `NOP_INSTR`, 8'h00: bubble encoding inserted on reset and flush.
- `CNT_W`, 8: stall counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `stall` in 1: from the hazard detection unit; hold PC and IF/ID.
- `branch_taken` in 1: from Execute; redirect PC and flush IF/ID.
- `branch_target` in PC_W: redirect address, sampled when `branch_taken`=1.
- `imem_addr` out PC_W: equals the PC register (combinational copy).
- `imem_rdata` in INSTR_W: asynchronous-read instruction memory data for `imem_addr`, valid in the same cycle.
- `if_id_instr` out INSTR_W: registered instruction.
- `if_id_pc` out PC_W: registered PC of `if_id_instr`.
- `if_id_valid` out 1: 1 when `if_id_instr` is a real fetched instruction; 0 for a bubble.
- `id_src_reg1` out 2: `if_id_instr[3:2]`, combinational.
- `id_src_reg2` out 2: `if_id_instr[1:0]`, combinational.
- `stall_cycles` out CNT_W: saturating count of cycles frozen by `stall`.

## Operation
Each rising edge applies exactly one action. Priority from highest to lowest:
- **Reset** (`rst_n`=0):
  - PC=RESET_PC.
  - `if_id_instr`=NOP_INSTR, `if_id_pc`=0, `if_id_valid`=0.
  - `stall_cycles`=0.
  - Overrides all other inputs.
- **Flush** (`branch_taken`=1):
  - PC=`branch_target`.
  - `if_id_instr`=NOP_INSTR, `if_id_pc`=0, `if_id_valid`=0.
  - Wins over `stall`: the stalled ID instruction is younger than the branch and is discarded.
  - `stall_cycles` is not incremented.
- **Stall** (`stall`=1, `branch_taken`=0):
  - PC, `if_id_instr`, `if_id_pc` and `if_id_valid` all hold.
  - `imem_rdata` is ignored.
  - `stall_cycles` increments by 1, saturating at 2^CNT_W-1 with no wrap.
- **Advance** (otherwise):
  - `if_id_instr`=`imem_rdata`, `if_id_pc`=PC, `if_id_valid`=1.
  - PC=PC+1 modulo 2^PC_W, so 8'hFF wraps to 8'h00 with no flag.

Other rules:
- `id_src_reg1` and `id_src_reg2` always reflect `if_id_instr`, including bubbles, where both are 0. The downstream hazard logic depends on `ex_mem_read`=0 for bubbles, not on `if_id_valid`.
- No state besides PC, the IF/ID register and the counter.

## Timing
- Fetch-to-decode latency is one cycle: the instruction at PC=A appears on `if_id_instr` in the cycle after `imem_addr`=A, if not stalled.
- A stall lasting N consecutive cycles extends that instruction's residency in ID by exactly N cycles. On the first non-stall cycle, the instruction at the held PC is latched.
- Branch redirect: `imem_addr`=`branch_target` in the cycle after `branch_taken`. IF/ID shows one bubble in that same cycle, and the target instruction appears one cycle later.
- `stall`, `branch_taken` and `branch_target` must be stable before the edge. They are not registered internally.
- In the first cycle after reset deasserts, `if_id_valid`=0 and `imem_addr`=RESET_PC.

## Test plan
- **Reset then free-run:** hold `rst_n`=0 for 2 cycles, then release; memory returns 8'h10+addr. Required:
  - Outputs are at reset values while in reset.
  - `imem_addr` reads 0,1,2,3 on successive cycles.
  - `if_id_instr` reads 8'h10, 8'h11, 8'h12 starting one cycle after release.
  - `if_id_valid` rises one cycle after release.
- **Stall hold:** assert `stall` for 3 cycles while `if_id_instr`=8'h12 and PC=3. Required:
  - PC=3 and `if_id_instr`=8'h12 for all 3 cycles.
  - `stall_cycles`=3.
  - On release, `if_id_instr`=8'h13.
- **Branch during stall:** assert `stall`=1 and `branch_taken`=1 with `branch_target`=8'h40. Required:
  - Next cycle: PC=8'h40, `if_id_valid`=0, `if_id_instr`=8'h00, `id_src_reg1`=`id_src_reg2`=0, `stall_cycles` unchanged.
  - Following cycle: `if_id_instr`=8'h50 and `if_id_pc`=8'h40.
- **PC wrap:** set PC to 8'hFE via branch, then advance. Required:
  - `imem_addr` reads FE, FF, 00.
  - `if_id_pc` reads FF, then 00.
- **Counter saturation:** hold `stall` for 300 cycles. Required: `stall_cycles` stops at 255.
- **Reset mid-operation:** pull `rst_n` low while `stall`=1 and `branch_taken`=1. Required:
  - Next cycle: PC=RESET_PC, `if_id_valid`=0, `stall_cycles`=0.
  - The branch target is ignored.
